// File: rtl/wr_bram_row_pkg.sv
// Shared widths and FSM encoding for the top-row BRAM writer and the port-b row reader.
//   DATA_W : BRAM word width, one DDR beat per word
//   ADDR_W : BRAM address width
//   state_t: writer FSM states
package wr_bram_row_pkg;

  localparam int unsigned DATA_W = 512;
  localparam int unsigned ADDR_W = 13;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StDone
  } state_t;

endpackage

// File: rtl/wr_bram_row.sv
// Writes one row transaction from the DDR beat stream into the top-row BRAM through port a.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   wr_data_bram_row_start       : one-cycle pulse starting a transaction (ignored while busy)
//   wr_data_bram_row_ith_offset  : base BRAM address, sampled on an accepted start
//   wr_data_bram_row_num         : number of beats to write, sampled on an accepted start
//   wr_data_valid/last/in        : incoming beat stream
//   wr_data_bram_row_busy        : transaction in progress
//   wr_data_bram_row_ena/wea     : port a enable / write enable
//   wr_data_bram_row_addra/dina  : port a address / write data (zero when not writing)
//   wr_data_bram_row_done        : one-cycle pulse at transaction end
//   wr_data_bram_row_err         : last/count mismatch, sticky until the next accepted start
module wr_bram_row
  import wr_bram_row_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_data_bram_row_start,
  input  logic [ADDR_W-1:0] wr_data_bram_row_ith_offset,
  input  logic [ADDR_W-1:0] wr_data_bram_row_num,
  input  logic              wr_data_valid,
  input  logic              wr_data_last,
  input  logic [DATA_W-1:0] wr_data_in,
  output logic              wr_data_bram_row_busy,
  output logic              wr_data_bram_row_ena,
  output logic              wr_data_bram_row_wea,
  output logic [ADDR_W-1:0] wr_data_bram_row_addra,
  output logic [DATA_W-1:0] wr_data_bram_row_dina,
  output logic              wr_data_bram_row_done,
  output logic              wr_data_bram_row_err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              ena_q, ena_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [DATA_W-1:0] dina_q, dina_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ena_d   = 1'b0;
    addra_d = '0;
    dina_d  = '0;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Beats arriving here are dropped without touching err.
        if (wr_data_bram_row_start) begin
          err_d = 1'b0;
          if (wr_data_bram_row_num != '0) begin
            addr_d  = wr_data_bram_row_ith_offset;
            cnt_d   = wr_data_bram_row_num;
            state_d = StWrite;
          end else begin
            state_d = StDone;
          end
        end
      end

      StWrite: begin
        if (wr_data_valid) begin
          ena_d   = 1'b1;
          addra_d = addr_q;
          dina_d  = wr_data_in;
          addr_d  = addr_q + 1'b1;  // wraps modulo 2^ADDR_W
          cnt_d   = cnt_q - 1'b1;
          // The transaction ends on whichever of count-exhausted or last comes first;
          // it is clean only when both coincide on the same beat.
          if (cnt_q == ADDR_W'(1) || wr_data_last) begin
            state_d = StDone;
            err_d   = !(wr_data_last && cnt_q == ADDR_W'(1));
          end
        end
      end

      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      ena_q   <= 1'b0;
      addra_q <= '0;
      dina_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ena_q   <= ena_d;
      addra_q <= addra_d;
      dina_q  <= dina_d;
      done_q  <= done_d;
    end
  end

  // Busy covers WRITE and DONE, so it falls in the same cycle the done pulse appears.
  assign wr_data_bram_row_busy  = (state_q != StIdle);
  assign wr_data_bram_row_ena   = ena_q;
  assign wr_data_bram_row_wea   = ena_q;
  assign wr_data_bram_row_addra = addra_q;
  assign wr_data_bram_row_dina  = dina_q;
  assign wr_data_bram_row_done  = done_q;
  assign wr_data_bram_row_err   = err_q;

endmodule

// File: tb/tb_wr_bram_row.sv
// Self-checking bench for wr_bram_row: scoreboard of expected BRAM writes plus
// per-scenario checks of done timing, err and reset behaviour.
module tb_wr_bram_row;
  import wr_bram_row_pkg::*;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] num;
  logic              valid;
  logic              last;
  logic [DATA_W-1:0] din;
  logic              busy;
  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic              done;
  logic              err;

  wr_bram_row dut (
    .clk                         (clk),
    .rst                         (rst),
    .wr_data_bram_row_start      (start),
    .wr_data_bram_row_ith_offset (offset),
    .wr_data_bram_row_num        (num),
    .wr_data_valid               (valid),
    .wr_data_last                (last),
    .wr_data_in                  (din),
    .wr_data_bram_row_busy       (busy),
    .wr_data_bram_row_ena        (ena),
    .wr_data_bram_row_wea        (wea),
    .wr_data_bram_row_addra      (addra),
    .wr_data_bram_row_dina       (dina),
    .wr_data_bram_row_done       (done),
    .wr_data_bram_row_err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t sb[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  wr_cyc = -10;
  int  done_cyc = -10;
  int  done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every presented write must match the oldest expected write.
  always @(negedge clk) begin
    if (ena) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", addra, dina);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (wea !== 1'b1 || addra !== e.addr || dina !== e.data) begin
          fails++;
          $display("FAIL write_match: got wea=%b addr=%h data=%h, required wea=1 addr=%h data=%h",
                   wea, addra, dina, e.addr, e.data);
        end
      end
      wr_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] rand_beat();
    logic [DATA_W-1:0] v;
    for (int k = 0; k < DATA_W / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic do_start(input logic [ADDR_W-1:0] off, input logic [ADDR_W-1:0] n);
    start  = 1'b1;
    offset = off;
    num    = n;
    step();
    start  = 1'b0;
  endtask

  // Drive one beat; push it to the scoreboard when a write is expected.
  task automatic beat(input logic [ADDR_W-1:0] exp_addr, input logic is_last,
                      input logic expect_wr);
    wr_t e;
    valid = 1'b1;
    last  = is_last;
    din   = rand_beat();
    if (expect_wr) begin
      e.addr = exp_addr;
      e.data = din;
      sb.push_back(e);
    end
    step();
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 8 && done_cnt < target; i++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests++;
    if ({busy, ena, wea, addra, dina, done, err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%b ena=%b wea=%b addra=%h done=%b err=%b, required all 0",
               busy, ena, wea, addra, done, err);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int d0 = done_cnt;
    do_start(13'h0100, 13'd4);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_busy: got %b, required 1", busy);
    end
    for (int i = 0; i < 4; i++) beat(ADDR_W'(13'h0100 + i), i == 3, 1'b1);
    wait_done(d0 + 1);
    tests++;
    if (done_cnt != d0 + 1 || done_cyc != wr_cyc + 1) begin
      fails++;
      $display("FAIL basic_done: got count=%0d at cycle %0d, required count=%0d at cycle %0d",
               done_cnt - d0, done_cyc, 1, wr_cyc + 1);
    end
    tests++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_err_busy: got err=%b busy=%b, required 0 0", err, busy);
    end
  endtask

  task automatic test_gapped();
    int d0 = done_cnt;
    do_start(13'h0200, 13'd3);
    for (int i = 0; i < 3; i++) begin
      beat(ADDR_W'(13'h0200 + i), i == 2, 1'b1);
      if (i != 2) begin
        step();
        step();
      end
    end
    wait_done(d0 + 1);
    tests++;
    if (done_cnt != d0 + 1 || done_cyc != wr_cyc + 1) begin
      fails++;
      $display("FAIL gapped_done: got count=%0d at cycle %0d, required count=1 at cycle %0d",
               done_cnt - d0, done_cyc, wr_cyc + 1);
    end
  endtask

  task automatic test_wrap();
    int d0 = done_cnt;
    logic [ADDR_W-1:0] a;
    a = 13'h1FFE;
    do_start(a, 13'd4);
    for (int i = 0; i < 4; i++) begin
      beat(a, i == 3, 1'b1);
      a = a + 1'b1;
    end
    wait_done(d0 + 1);
    tests++;
    if (done_cnt != d0 + 1 || err !== 1'b0) begin
      fails++;
      $display("FAIL wrap_done: got count=%0d err=%b, required count=1 err=0", done_cnt - d0, err);
    end
  endtask

  task automatic test_early_last();
    int d0 = done_cnt;
    do_start(13'h0500, 13'd5);
    beat(13'h0500, 1'b0, 1'b1);
    beat(13'h0501, 1'b1, 1'b1);
    beat(13'h0502, 1'b0, 1'b0);  // arrives after the end: must not be written
    wait_done(d0 + 1);
    tests++;
    if (done_cnt != d0 + 1 || done_cyc != wr_cyc + 1) begin
      fails++;
      $display("FAIL early_done: got count=%0d at cycle %0d, required count=1 at cycle %0d",
               done_cnt - d0, done_cyc, wr_cyc + 1);
    end
    tests++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL early_err: got %b, required 1", err);
    end
    do_start(13'h0600, 13'd1);
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL early_err_clear: got %b, required 0", err);
    end
    beat(13'h0600, 1'b1, 1'b1);
    wait_done(d0 + 2);
    tests++;
    if (done_cnt != d0 + 2 || err !== 1'b0) begin
      fails++;
      $display("FAIL single_beat: got count=%0d err=%b, required count=1 err=0",
               done_cnt - d0 - 1, err);
    end
  endtask

  task automatic test_missing_last();
    int d0 = done_cnt;
    do_start(13'h0300, 13'd2);
    beat(13'h0300, 1'b0, 1'b1);
    do_start(13'h0800, 13'd7);  // ignored: transaction in progress
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL ignored_start_busy: got %b, required 1", busy);
    end
    beat(13'h0301, 1'b0, 1'b1);
    wait_done(d0 + 1);
    tests++;
    if (done_cnt != d0 + 1 || done_cyc != wr_cyc + 1 || err !== 1'b1) begin
      fails++;
      $display("FAIL missing_last: got count=%0d cycle=%0d err=%b, required count=1 cycle=%0d err=1",
               done_cnt - d0, done_cyc, err, wr_cyc + 1);
    end
  endtask

  task automatic test_zero_count();
    int d0 = done_cnt;
    do_start(13'h0700, 13'd0);
    wait_done(d0 + 1);
    step();
    tests++;
    if (done_cnt != d0 + 1 || err !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_count: got count=%0d err=%b busy=%b, required count=1 err=0 busy=0",
               done_cnt - d0, err, busy);
    end
  endtask

  task automatic test_mid_reset();
    int d0 = done_cnt;
    do_start(13'h0400, 13'd4);
    beat(13'h0400, 1'b0, 1'b1);
    // Second beat coincides with reset and must be dropped.
    rst   = 1'b1;
    valid = 1'b1;
    din   = rand_beat();
    step();
    rst   = 1'b0;
    valid = 1'b0;
    tests++;
    if ({busy, ena, wea, addra, dina, done} !== '0) begin
      fails++;
      $display("FAIL reset_abort: got busy=%b ena=%b wea=%b addra=%h done=%b, required all 0",
               busy, ena, wea, addra, done);
    end
    beat(13'h0000, 1'b1, 1'b0);  // stray beat in IDLE: dropped, no err
    for (int i = 0; i < 4; i++) step();
    tests++;
    if (done_cnt != d0 || busy !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: got done_count=%0d busy=%b err=%b, required 0 0 0",
               done_cnt - d0, busy, err);
    end
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    offset = '0;
    num    = '0;
    valid  = 1'b0;
    last   = 1'b0;
    din    = '0;
    test_reset();
    test_basic();
    test_gapped();
    test_wrap();
    test_early_last();
    test_missing_last();
    test_zero_count();
    test_mid_reset();
    step();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending writes, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wr_bram_row.md
# wr_bram_row

Writes one row transaction (top row of the processing registers for the i-th bottom feature map) into the top-row BRAM through port a, so the existing port-b row reader can fetch it later. It sits between the DDR fetch path, which streams 512-bit beats with valid/last, and the dual-port top-row BRAM. It owns address generation, beat counting and transaction completion.

## Interface
- DATA_W, 512, BRAM data width (one beat = one BRAM word)
- ADDR_W, 13, BRAM address width
- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- wr_data_bram_row_start  in  1  one-cycle pulse; begins a transaction
- wr_data_bram_row_ith_offset  in  ADDR_W  base address; sampled on start only
- wr_data_bram_row_num  in  ADDR_W  beats to write; sampled on start only
- wr_data_valid  in  1  beat present on wr_data_in
- wr_data_last  in  1  marks final beat; qualified by wr_data_valid
- wr_data_in  in  DATA_W  beat payload
- wr_data_bram_row_busy  out  1  transaction in progress; start ignored while high
- wr_data_bram_row_ena  out  1  port a enable
- wr_data_bram_row_wea  out  1  port a write enable
- wr_data_bram_row_addra  out  ADDR_W  port a address
- wr_data_bram_row_dina  out  DATA_W  port a write data
- wr_data_bram_row_done  out  1  one-cycle pulse at transaction end
- wr_data_bram_row_err  out  1  last/count mismatch; sticky until next accepted start

## Operation
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - start=1 and num!=0: latch offset into the address counter and num into the beat counter; set busy; go to WRITE.
  - start=1 and num==0: go to DONE directly; no BRAM write; err=0.
  - valid beats arriving in IDLE are dropped and do not set err.
- WRITE, on each valid beat:
  - register ena=wea=1, addra=current address, dina=wr_data_in.
  - increment the address modulo 2^ADDR_W; 0x1FFF wraps to 0x0000.
  - decrement the remaining count.
- WRITE, ending the transaction on the final beat (remaining==1 or last=1, whichever comes first):
  - write that beat, then go to DONE.
  - err=1 if last=1 arrives with remaining>1 (early last).
  - err=1 if remaining reaches 0 without last on that beat (missing last).
  - beats after the end are dropped.
- DONE: pulse done for one cycle, clear busy, go to IDLE.
- A start pulse while busy is ignored and does not change state, counters or err.
- An accepted start clears err.

## Timing
- Reset values: all outputs 0; FSM=IDLE; counters 0.
- Reset asserted mid-transaction aborts it on the next edge: no done pulse, any pending write is dropped, and ena/wea are 0 in the cycle after the reset edge.
- start→busy: 1 cycle; the first beat may arrive in the cycle after start.
- Beat→BRAM write: 1 cycle (ena/wea/addra/dina registered); one write per valid beat, no bubbles.
- When no write occurs, ena/wea are 0 and addra/dina hold 0.
- Final write and transition to DONE happen in the same cycle. done is asserted the cycle after the final write is presented, and busy falls on that same cycle.
- Minimum gap start→start is N+2 cycles for num=N.

## Structure
- Shared package holds DATA_W, ADDR_W and the FSM state enum (IDLE/WRITE/DONE). The port-b row reader uses the same widths.
- Single module, no sub-module. The address and beat counters are simple enough to live inline.

## Test plan
- Basic write: start, offset=0x0100, num=4; four consecutive valid beats D0..D3, last on D3 → writes at 0x0100..0x0103 with D0..D3; done one cycle after the D3 write; err=0.
- Gapped input: num=3 with beats separated by 2 idle cycles each → three writes at consecutive addresses; no ena while input is idle; done after the third write.
- Wrap-around: offset=0x1FFE, num=4 → addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- Early last: num=5, last on the 2nd beat → 2 writes, done, err=1. A 3rd beat sent afterwards is not written. The next start clears err.
- Missing last / ignored start: num=2, no last on either beat → 2 writes, done, err=1. A start pulsed mid-transaction with a different offset does not alter the addresses.
- Zero count and reset: num=0 → done one cycle after start with no write. Reset asserted after 1 of 4 beats → outputs 0 next cycle, no done, FSM=IDLE.
